// File: rtl/tile_seq_pkg.sv
// rtl/tile_seq_pkg.sv - shared state, opcode and phase-length definitions for the tile sequencer
package tile_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    WLOAD = 3'd2,
    COMP  = 3'd3,
    DRAIN = 3'd4,
    INTRA = 3'd5,
    FIN   = 3'd6
  } tile_state_e;

  // Opcodes understood by systolic_array on operation_signal_in
  localparam logic [2:0] OP_IDLE  = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_COMP  = 3'd2;
  localparam logic [2:0] OP_DRAIN = 3'd3;

  // Cycles spent in a phase; INTRA reports its safety timeout, COMP covers skew fill and flush
  function automatic int phase_len(input tile_state_e st, input int k, input int an, input int am);
    case (st)
      WLOAD:   return an;
      COMP:    return k + an + am - 2;
      DRAIN:   return am;
      INTRA:   return 4 * an * am;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/systolic_tile_sequencer_phase_counter.sv
// rtl/systolic_tile_sequencer_phase_counter.sv - loadable down-counter with zero flag, reused for every phase
module tile_phase_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // Load on phase entry, otherwise count down and park at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/systolic_tile_sequencer.sv
// rtl/systolic_tile_sequencer.sv - GEMM tile control FSM for systolic_system_adv (INTRA copy phase under TILE_SEQ_INTRANET_EN)
module systolic_tile_sequencer
  import tile_seq_pkg::*;
#(
  parameter int ARRAY_N    = 16,
  parameter int ARRAY_M    = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 8,
  parameter int K_MAX      = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [$clog2(ARRAY_N):0] cfg_rows,
  input  logic [$clog2(ARRAY_N):0] cfg_cols,
  input  logic [CNT_WIDTH-1:0]     cfg_k,
  input  logic [ADDR_WIDTH-1:0]    cfg_a_base,
  input  logic [ADDR_WIDTH-1:0]    cfg_w_base,
  input  logic [ADDR_WIDTH-1:0]    cfg_o_base,
  input  logic                     cfg_chain,
  input  logic                     Intra_sig_end,
  output logic                     sa_reset,
  output logic                     a_buf_on,
  output logic                     w_buf_on,
  output logic                     mode,
  output logic                     o_ag_o_on,
  output logic                     Intranet_on,
  output logic                     Intra_sig_start,
  output logic [2:0]               operation_signal,
  output logic [ADDR_WIDTH-1:0]    a_base_addr,
  output logic [ADDR_WIDTH-1:0]    w_base_addr,
  output logic [ADDR_WIDTH-1:0]    o_base_addr,
  output logic [$clog2(ARRAY_N):0] a_num_rows,
  output logic [$clog2(ARRAY_N):0] w_num_cols,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

`ifdef TILE_SEQ_INTRANET_EN
  // The INTRA timeout is longer than any compute phase, so the shared counter widens to hold it
  localparam int TMO_W = $clog2(4 * ARRAY_N * ARRAY_M) + 1;
  localparam int PC_W  = (TMO_W > CNT_WIDTH) ? TMO_W : CNT_WIDTH;
`else
  localparam int PC_W  = CNT_WIDTH;
`endif

  tile_state_e          state, state_next;
  logic [CNT_WIDTH-1:0] k_q;
  logic [PC_W-1:0]      cnt, cnt_load_val;
  logic                 cnt_load, cnt_zero;
  logic                 bad_cfg, accept;
  logic                 sa_reset_d, a_buf_on_d, w_buf_on_d, mode_d, o_ag_o_on_d;
  logic                 busy_d, done_d, err_d;
  logic [2:0]           op_d;

  assign bad_cfg = (cfg_rows == '0) || (cfg_cols == '0) || (cfg_k == '0) || (int'(cfg_k) > K_MAX);
  assign accept  = (state == IDLE) && start;

  // Every phase reloads the counter with its length minus one on entry
  assign cnt_load     = (state_next != state);
  assign cnt_load_val = PC_W'(phase_len(state_next, int'(k_q), ARRAY_N, ARRAY_M) - 1);

  tile_phase_counter #(.WIDTH(PC_W)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

`ifdef TILE_SEQ_INTRANET_EN
  logic chain_q, intranet_on_d, intra_start_d, intra_timeout;
  assign intra_timeout = (state == INTRA) && cnt_zero && !Intra_sig_end;
`endif

  // Next-state: each timed phase exits when its counter has reached zero
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !bad_cfg) state_next = CLR;
      CLR:     if (cnt_zero) state_next = WLOAD;
      WLOAD:   if (cnt_zero) state_next = COMP;
      COMP:    if (cnt_zero) state_next = DRAIN;
`ifdef TILE_SEQ_INTRANET_EN
      DRAIN:   if (cnt_zero) state_next = chain_q ? INTRA : FIN;
      INTRA:   if (Intra_sig_end || cnt_zero) state_next = FIN;
`else
      DRAIN:   if (cnt_zero) state_next = FIN;
`endif
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decode the controls for the upcoming cycle so they can be registered on the transition edge
  always_comb begin
    sa_reset_d  = (state_next == CLR);
    w_buf_on_d  = (state_next == WLOAD) || (state_next == COMP);
    mode_d      = (state_next == WLOAD);
    // Activations stream for the first k COMP cycles only; the rest is skew flush
    a_buf_on_d  = (state_next == COMP) &&
                  ((state != COMP) || (int'(cnt) >= ARRAY_N + ARRAY_M - 1));
    o_ag_o_on_d = (state_next == DRAIN);
    busy_d      = (state_next != IDLE) && (state_next != FIN);
    done_d      = (state_next == FIN) || (accept && bad_cfg);
    case (state_next)
      WLOAD:   op_d = OP_LOAD;
      COMP:    op_d = OP_COMP;
      DRAIN:   op_d = OP_DRAIN;
      default: op_d = OP_IDLE;
    endcase
    err_d = err;
    if (accept) err_d = bad_cfg;
`ifdef TILE_SEQ_INTRANET_EN
    else if (intra_timeout) err_d = 1'b1;
    intranet_on_d = (state_next == INTRA);
    intra_start_d = (state_next == INTRA) && (state != INTRA);
`endif
  end

  // Registered control outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sa_reset         <= 1'b0;
      a_buf_on         <= 1'b0;
      w_buf_on         <= 1'b0;
      mode             <= 1'b0;
      o_ag_o_on        <= 1'b0;
      operation_signal <= OP_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      sa_reset         <= sa_reset_d;
      a_buf_on         <= a_buf_on_d;
      w_buf_on         <= w_buf_on_d;
      mode             <= mode_d;
      o_ag_o_on        <= o_ag_o_on_d;
      operation_signal <= op_d;
      busy             <= busy_d;
      done             <= done_d;
      err              <= err_d;
    end
  end

  // Configuration is captured once per accepted start and held for the whole tile
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_base_addr <= '0;
      w_base_addr <= '0;
      o_base_addr <= '0;
      a_num_rows  <= '0;
      w_num_cols  <= '0;
      k_q         <= '0;
    end else if (accept) begin
      a_base_addr <= cfg_a_base;
      w_base_addr <= cfg_w_base;
      o_base_addr <= cfg_o_base;
      a_num_rows  <= cfg_rows;
      w_num_cols  <= cfg_cols;
      k_q         <= cfg_k;
    end
  end

`ifdef TILE_SEQ_INTRANET_EN
  // Chain flag and Intra_net handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain_q         <= 1'b0;
      Intranet_on     <= 1'b0;
      Intra_sig_start <= 1'b0;
    end else begin
      if (accept) chain_q <= cfg_chain;
      Intranet_on     <= intranet_on_d;
      Intra_sig_start <= intra_start_d;
    end
  end
`else
  logic unused_intra;
  assign unused_intra    = &{1'b0, cfg_chain, Intra_sig_end};
  assign Intranet_on     = 1'b0;
  assign Intra_sig_start = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// tb/tb_systolic_tile_sequencer.sv - randomized self-checking bench for systolic_tile_sequencer
module tb_systolic_tile_sequencer;

  localparam int N   = 16;
  localparam int M   = 16;
  localparam int AW  = 10;
  localparam int CW  = 8;
  localparam int KM  = 64;
  localparam int DW  = 5;
  localparam int TMO = 4 * N * M;
`ifdef TILE_SEQ_INTRANET_EN
  localparam bit INTRA_EN = 1'b1;
`else
  localparam bit INTRA_EN = 1'b0;
`endif

  logic          clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [DW-1:0] cfg_rows = '0, cfg_cols = '0;
  logic [CW-1:0] cfg_k = '0;
  logic [AW-1:0] cfg_a_base = '0, cfg_w_base = '0, cfg_o_base = '0;
  logic          cfg_chain = 1'b0, Intra_sig_end = 1'b0;
  logic          sa_reset, a_buf_on, w_buf_on, mode, o_ag_o_on, Intranet_on, Intra_sig_start;
  logic [2:0]    operation_signal;
  logic [AW-1:0] a_base_addr, w_base_addr, o_base_addr;
  logic [DW-1:0] a_num_rows, w_num_cols;
  logic          busy, done, err;

  int checks = 0;
  int failures = 0;

  logic [12:0] obs_ctrl;
  logic [39:0] obs_cfg;
  assign obs_ctrl = {sa_reset, a_buf_on, w_buf_on, mode, o_ag_o_on, Intranet_on, Intra_sig_start,
                     operation_signal, busy, done, err};
  assign obs_cfg  = {a_base_addr, w_base_addr, o_base_addr, a_num_rows, w_num_cols};

  always #5 clk = ~clk;

  systolic_tile_sequencer #(
    .ARRAY_N(N), .ARRAY_M(M), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .K_MAX(KM)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_k(cfg_k),
    .cfg_a_base(cfg_a_base), .cfg_w_base(cfg_w_base), .cfg_o_base(cfg_o_base),
    .cfg_chain(cfg_chain), .Intra_sig_end(Intra_sig_end),
    .sa_reset(sa_reset), .a_buf_on(a_buf_on), .w_buf_on(w_buf_on), .mode(mode),
    .o_ag_o_on(o_ag_o_on), .Intranet_on(Intranet_on), .Intra_sig_start(Intra_sig_start),
    .operation_signal(operation_signal),
    .a_base_addr(a_base_addr), .w_base_addr(w_base_addr), .o_base_addr(o_base_addr),
    .a_num_rows(a_num_rows), .w_num_cols(w_num_cols),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Tile timeline: 1 clear cycle, N load, k+N+M-2 compute, M drain, li copy, then one done cycle
  function automatic logic [12:0] model_ctrl(input int t, input int k, input int li, input bit tmo);
    int   t_c = 2 + N;
    int   t_d = t_c + k + N + M - 2;
    int   t_i = t_d + M;
    int   t_f = t_i + li;
    logic sa = 1'b0, a_on = 1'b0, w_on = 1'b0, md = 1'b0, o_on = 1'b0;
    logic i_on = 1'b0, i_st = 1'b0, bz = 1'b0, dn = 1'b0, er = 1'b0;
    logic [2:0] op = 3'd0;
    if (t == 1) begin
      sa = 1'b1; bz = 1'b1;
    end else if (t < t_c) begin
      w_on = 1'b1; md = 1'b1; op = 3'd1; bz = 1'b1;
    end else if (t < t_d) begin
      w_on = 1'b1; a_on = ((t - t_c) < k); op = 3'd2; bz = 1'b1;
    end else if (t < t_i) begin
      o_on = 1'b1; op = 3'd3; bz = 1'b1;
    end else if (t < t_f) begin
      i_on = 1'b1; i_st = (t == t_i); bz = 1'b1;
    end else if (t == t_f) begin
      dn = 1'b1; er = tmo;
    end else begin
      er = tmo;
    end
    return {sa, a_on, w_on, md, o_on, i_on, i_st, op, bz, dn, er};
  endfunction

  // One tile from a negedge: end_at<0 means Intra_sig_end never comes, poke_at re-pulses start,
  // reset_at pulls reset mid-tile and abandons the run
  task automatic run_tile(input int rows, input int cols, input int k, input bit chain,
                          input int end_at, input int poke_at, input int reset_at);
    logic [AW-1:0] ab, wb, ob;
    logic [39:0]   exp_cfg;
    int            li, total, t_i;
    bit            tmo;
    ab = AW'($urandom); wb = AW'($urandom); ob = AW'($urandom);
    li = 0; tmo = 1'b0;
    if (INTRA_EN && chain) begin
      if (end_at < 0 || end_at >= TMO) begin li = TMO; tmo = 1'b1; end
      else li = end_at + 1;
    end
    t_i     = 2 + N + (k + N + M - 2) + M;
    total   = t_i + li;
    exp_cfg = {ab, wb, ob, DW'(rows), DW'(cols)};
    cfg_rows = DW'(rows); cfg_cols = DW'(cols); cfg_k = CW'(k);
    cfg_a_base = ab; cfg_w_base = wb; cfg_o_base = ob; cfg_chain = chain;
    Intra_sig_end = 1'($urandom_range(0, 1));
    start = 1'b1;
    for (int t = 1; t <= total + 2; t++) begin
      @(negedge clk);
      check($sformatf("ctrl k=%0d t=%0d", k, t), 64'(obs_ctrl), 64'(model_ctrl(t, k, li, tmo)));
      check($sformatf("cfg k=%0d t=%0d", k, t), 64'(obs_cfg), 64'(exp_cfg));
      if (t == reset_at) begin
        start = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("reset_mid ctrl", 64'(obs_ctrl), 64'd0);
        check("reset_mid cfg", 64'(obs_cfg), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      cfg_rows = DW'($urandom); cfg_cols = DW'($urandom); cfg_k = CW'($urandom);
      cfg_a_base = AW'($urandom); cfg_w_base = AW'($urandom); cfg_o_base = AW'($urandom);
      cfg_chain = 1'($urandom_range(0, 1));
      start = (t == poke_at);
      if (li > 0 && t >= t_i && t < t_i + li) Intra_sig_end = (t == t_i + end_at);
      else Intra_sig_end = 1'($urandom_range(0, 1));
    end
  endtask

  // Rejected configuration: err and done one cycle later, nothing else moves
  task automatic bad_start(input int rows, input int cols, input int k);
    logic [39:0] exp_cfg;
    cfg_rows = DW'(rows); cfg_cols = DW'(cols); cfg_k = CW'(k);
    cfg_a_base = AW'($urandom); cfg_w_base = AW'($urandom); cfg_o_base = AW'($urandom);
    exp_cfg = {cfg_a_base, cfg_w_base, cfg_o_base, cfg_rows, cfg_cols};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("bad k=%0d r=%0d c=%0d t1", k, rows, cols), 64'(obs_ctrl), 64'h003);
    check("bad cfg latched", 64'(obs_cfg), 64'(exp_cfg));
    @(negedge clk);
    check($sformatf("bad k=%0d r=%0d c=%0d t2", k, rows, cols), 64'(obs_ctrl), 64'h001);
  endtask

  initial begin
    #1;
    check("reset ctrl", 64'(obs_ctrl), 64'd0);
    check("reset cfg", 64'(obs_cfg), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle ctrl", 64'(obs_ctrl), 64'd0);

    run_tile(16, 16, 16, 1'b0, -1, 0, 0);
    bad_start(16, 16, 0);
    bad_start(16, 16, KM + 1);
    bad_start(0, 16, 8);
    bad_start(16, 0, 8);
    run_tile(16, 16, KM, 1'b0, -1, 0, 0);
    run_tile(8, 12, 5, 1'b0, -1, 5, 0);
    run_tile(16, 16, 16, 1'b0, -1, 0, 2 + N + 9);
    run_tile(16, 16, 16, 1'b0, -1, 0, 0);
    run_tile(1, 1, 1, 1'b1, 3, 0, 0);
    for (int i = 0; i < 5; i++) begin
      run_tile(int'($urandom_range(1, N)), int'($urandom_range(1, N)), int'($urandom_range(1, KM)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 40)),
               int'($urandom_range(0, 30)), 0);
    end
`ifdef TILE_SEQ_INTRANET_EN
    run_tile(16, 16, 16, 1'b1, 20, 0, 0);
    run_tile(4, 4, 8, 1'b1, 0, 0, 0);
    run_tile(16, 16, 16, 1'b1, -1, 0, 0);
    run_tile(16, 16, 4, 1'b0, -1, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_tile_sequencer.md
Name: systolic_tile_sequencer

Overview:
- Control FSM that runs one complete GEMM tile on systolic_system_adv.
- Sequence per tile: SA clear, weight preload, activation streaming/compute, output drain to O buffer, optional Intra_net O->A copy.
- Sits between the host register file and systolic_system_adv.
- Drives every FSM-labelled control input of that block; replaces hand-sequenced testbench control.

Parameters:
- ARRAY_N, 16, SA rows / activation lanes
- ARRAY_M, 16, SA columns / weight lanes
- ADDR_WIDTH, 10, buffer address width
- CNT_WIDTH, 8, phase cycle-counter width; must hold K_MAX + ARRAY_N + ARRAY_M
- K_MAX, 64, largest legal reduction length (activation rows per tile)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- cfg_rows  in  $clog2(ARRAY_N)+1  activation rows (M); drives a_num_rows
- cfg_cols  in  $clog2(ARRAY_N)+1  weight columns (N); drives w_num_cols
- cfg_k  in  CNT_WIDTH  reduction length
- cfg_a_base / cfg_w_base / cfg_o_base  in  ADDR_WIDTH  base addresses, latched at start
- cfg_chain  in  1  run Intra_net copy after drain
- Intra_sig_end  in  1  copy-complete pulse from Intra_net_top
- sa_reset, a_buf_on, w_buf_on, mode, o_ag_o_on, Intranet_on, Intra_sig_start  out  1  array controls
- operation_signal  out  3  to operation_signal_in
- a_base_addr, w_base_addr, o_base_addr  out  ADDR_WIDTH  latched bases
- a_num_rows, w_num_cols  out  $clog2(ARRAY_N)+1  latched dims
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle completion pulse
- err  out  1  sticky config error; cleared by the next accepted start

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0; latched config 0; counter 0.
- States and exits (counter loaded on entry, decremented each cycle, exit when it reaches 0):
  - IDLE: on start, latch all cfg_*. If cfg_rows=0, cfg_cols=0, cfg_k=0 or cfg_k>K_MAX: set err, pulse done, stay IDLE. Otherwise set busy and go to CLR.
  - CLR: 1 cycle; sa_reset=1.
  - WLOAD: ARRAY_N cycles; w_buf_on=1, mode=1, operation_signal=OP_LOAD(3'd1).
  - COMP: cfg_k+ARRAY_N+ARRAY_M-2 cycles (skew fill/flush); a_buf_on=1, w_buf_on=1, mode=0, operation_signal=OP_COMP(3'd2). a_buf_on drops after the first cfg_k cycles.
  - DRAIN: ARRAY_M cycles; o_ag_o_on=1, operation_signal=OP_DRAIN(3'd3).
  - INTRA: only entered when cfg_chain=1 and the macro is enabled. Intranet_on=1 throughout; Intra_sig_start pulses on the first cycle; exit on Intra_sig_end.
  - FIN: 1 cycle; done=1; busy drops; return to IDLE.
- operation_signal is OP_IDLE(3'd0) in all other states.
- All control outputs are registered: they change on the clock edge of the state transition. There is no combinational path from inputs to outputs.
- start while busy: ignored, no queueing.
- Intra_sig_end asserted outside INTRA: ignored.
- Intra_sig_end in the same cycle as Intra_sig_start: exit after that cycle.
- Reset mid-tile: immediate return to IDLE; outputs cleared; a partial O-buffer write is left as is.
- cfg_* changes after start: no effect; values were latched.

Optional Feature:
- Macro TILE_SEQ_INTRANET_EN.
- Defined: INTRA state exists and cfg_chain is honoured. A safety timeout of 4*ARRAY_N*ARRAY_M cycles sets err and forces FIN.
- Undefined: INTRA state removed; cfg_chain ignored; Intranet_on and Intra_sig_start tied to 0; DRAIN goes directly to FIN.

Decomposition:
- Package tile_seq_pkg holds:
  - state enum (IDLE, CLR, WLOAD, COMP, DRAIN, INTRA, FIN)
  - OP_* 3-bit constants, shared with systolic_array
  - phase-length helper function
- One sub-module: tile_phase_counter (loadable down-counter with a zero flag), reused per phase.

Test Plan:
- Nominal tile: ARRAY 16x16, rows=16, cols=16, k=16, chain=0 -> sa_reset for 1 cycle, WLOAD 16 cycles, COMP 46 cycles, DRAIN 16 cycles; done pulses exactly 80 cycles after start; busy=1 throughout.
- Bad config: start with cfg_k=0, then with cfg_k=K_MAX+1 -> err=1 and done in the next cycle; no control output toggles. A following valid start clears err.
- Chained copy (macro on): chain=1, Intra_sig_end driven 20 cycles after Intra_sig_start -> Intranet_on high exactly 21 cycles; done on the following cycle.
- Intra timeout (macro on): Intra_sig_end never asserted -> err=1 and done after 1024 cycles in INTRA.
- Reset mid-COMP: reset low at COMP cycle 10 -> all outputs 0 immediately; a fresh start afterwards completes the nominal sequence.
- start during busy: pulse start in WLOAD with different cfg -> ignored; latched base addresses unchanged; a single done pulse.
